// File: rtl/reg_scan_if.sv
// reg_scan output stream: address/data beats on a valid/ready handshake.
// master = the dump engine, slave = the debug/trace consumer.
interface reg_scan_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_csum;

  modport master (
    output out_valid, out_addr, out_data, out_last, out_csum,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_addr, out_data, out_last, out_csum,
    output out_ready
  );
endinterface

// File: rtl/reg_scan.sv
// reg_scan: sequential register-file dump engine. On start it walks read
// addresses 0..NREGS-1, captures each value for one cycle and streams it out
// as address/data beats. Optional trailing checksum beat is enabled with the
// macro REG_SCAN_CHECKSUM_EN (mod-2^DW sum of the captured values).
module reg_scan #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  reg_scan_if.master    ob,
  output logic          busy,
  output logic          done
);

`ifdef REG_SCAN_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, CAPTURE, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CAPTURE, SEND, DONE} state_t;
`endif

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] out_addr_q, out_addr_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
`ifdef REG_SCAN_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
`endif

  // Next-state and datapath load decisions; everything holds by default.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_addr_d  = rd_addr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
`ifdef REG_SCAN_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d     = '0;
          rd_addr_d = '0;
`ifdef REG_SCAN_CHECKSUM_EN
          sum_d     = '0;
`endif
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        out_data_d = rd_data;
        out_addr_d = idx_q;
`ifdef REG_SCAN_CHECKSUM_EN
        sum_d      = sum_q + rd_data;
        out_last_d = 1'b0;
`else
        out_last_d = (idx_q == LAST_IDX);
`endif
        state_d    = SEND;
      end
      SEND: begin
        if (ob.out_ready) begin
          if (idx_q < LAST_IDX) begin
            // rd_addr is registered, so it is loaded with the next index on
            // the way into CAPTURE rather than decoded from idx.
            idx_d     = idx_q + 1'b1;
            rd_addr_d = idx_q + 1'b1;
            state_d   = CAPTURE;
          end else begin
            rd_addr_d = '0;
`ifdef REG_SCAN_CHECKSUM_EN
            out_data_d = sum_q;
            out_addr_d = '0;
            out_last_d = 1'b1;
            state_d    = CSUM;
`else
            state_d    = DONE;
`endif
          end
        end
      end
`ifdef REG_SCAN_CHECKSUM_EN
      CSUM: begin
        if (ob.out_ready) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rd_addr_q  <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
`ifdef REG_SCAN_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_addr_q  <= rd_addr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
`ifdef REG_SCAN_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  assign rd_addr      = rd_addr_q;
  assign ob.out_addr  = out_addr_q;
  assign ob.out_data  = out_data_q;
  assign ob.out_last  = out_last_q;
  assign done         = (state_q == DONE);
`ifdef REG_SCAN_CHECKSUM_EN
  assign ob.out_valid = (state_q == SEND) || (state_q == CSUM);
  assign ob.out_csum  = (state_q == CSUM);
  assign busy         = (state_q == CAPTURE) || (state_q == SEND) || (state_q == CSUM);
`else
  assign ob.out_valid = (state_q == SEND);
  assign ob.out_csum  = 1'b0;
  assign busy         = (state_q == CAPTURE) || (state_q == SEND);
`endif

endmodule

// File: tb/tb_reg_scan.sv
// Scoreboard bench for reg_scan: scans push the expected beat list (computed
// from the register contents the scan will observe) into a queue; a monitor
// pops and compares on every accepted beat and checks hold-stability.
module tb_reg_scan;
  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;
`ifdef REG_SCAN_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int DONE_CYC = 2 * NREGS + (CK ? 2 : 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] regs [NREGS];

  reg_scan_if #(.AW(AW), .DW(DW)) bus ();

  reg_scan #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .ob      (bus),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  assign rd_data = regs[rd_addr];

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic          csum;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: one beat per register in address order, then an optional
  // checksum beat carrying the sum of all values modulo 2^DW.
  task automatic push_expected(input logic [DW-1:0] vals [NREGS]);
    beat_t       b;
    int unsigned s;
    s = 0;
    for (int i = 0; i < NREGS; i++) begin
      b.addr = AW'(i);
      b.data = vals[i];
      b.last = (i == NREGS - 1) && !CK;
      b.csum = 1'b0;
      exp_q.push_back(b);
      s = s + int'(vals[i]);
    end
    if (CK) begin
      b.addr = '0;
      b.data = DW'(s % (1 << DW));
      b.last = 1'b1;
      b.csum = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  // Monitor: compares accepted beats, checks stability under backpressure.
  beat_t mon_cur, mon_held, mon_exp;
  bit    mon_hold = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      mon_hold = 1'b0;
    end else if (bus.out_valid) begin
      mon_cur = {bus.out_addr, bus.out_data, bus.out_last, bus.out_csum};
      if (mon_hold) chk("hold_stable", 32'(mon_cur), 32'(mon_held));
      if (bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(mon_cur), 32'hFFFF_FFFF);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("beat_addr", 32'(mon_cur.addr), 32'(mon_exp.addr));
          chk("beat_data", 32'(mon_cur.data), 32'(mon_exp.data));
          chk("beat_last", 32'(mon_cur.last), 32'(mon_exp.last));
          chk("beat_csum", 32'(mon_cur.csum), 32'(mon_exp.csum));
        end
        mon_hold = 1'b0;
      end else begin
        mon_held = mon_cur;
        mon_hold = 1'b1;
      end
    end else begin
      if (mon_hold) chk("valid_dropped", 32'(bus.out_valid), 32'd1);
      mon_hold = 1'b0;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_addr"},   32'(rd_addr),       32'd0);
    chk({tag, "_valid"},     32'(bus.out_valid), 32'd0);
    chk({tag, "_out_addr"},  32'(bus.out_addr),  32'd0);
    chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
    chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
    chk({tag, "_out_csum"},  32'(bus.out_csum),  32'd0);
    chk({tag, "_busy"},      32'(busy),          32'd0);
    chk({tag, "_done"},      32'(done),          32'd0);
  endtask

  // mode 0: plain, 1: backpressure on beat 3, 2: start while busy.
  // wb>=0 schedules regs[wj]=wv during the beat for address wb (wj>wb).
  task automatic run_scan(input int mode, input int wb, input int wj,
                          input logic [DW-1:0] wv, input bit rnd);
    logic [DW-1:0] fin [NREGS];
    int n, hold, rise_n, dcnt, bcnt;
    bit wrote, s1, seen;
    fin = regs;
    if (wb >= 0) fin[wj] = wv;
    push_expected(fin);
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1; hold = 0; rise_n = -10; wrote = 0; s1 = 0; seen = 0;
    while (n < 400) begin
      if (n == 1) begin
        chk("lat_c1_valid",  32'(bus.out_valid), 32'd0);
        chk("lat_c1_busy",   32'(busy),          32'd1);
        chk("lat_c1_rdaddr", 32'(rd_addr),       32'd0);
      end
      if (n == 2) begin
        chk("lat_c2_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_c2_addr",  32'(bus.out_addr),  32'd0);
      end
      if (done) begin
        seen = 1;
        break;
      end
      start = 1'b0;
      if (rnd) bus.out_ready = ($urandom_range(0, 2) != 0);
      if (wb >= 0 && !wrote && bus.out_valid && bus.out_addr == AW'(wb)) begin
        regs[wj] = wv;
        wrote = 1;
      end
      if (mode == 1) begin
        if (hold == 0 && rise_n < 0 && busy && !bus.out_valid && rd_addr == 3'd3) begin
          bus.out_ready = 1'b0;
          hold = 4;
        end else if (hold > 0) begin
          hold--;
          if (hold > 0) begin
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_addr",  32'(bus.out_addr),  32'd3);
            chk("bp_data",  32'(bus.out_data),  32'(fin[3]));
          end else begin
            bus.out_ready = 1'b1;
            rise_n = n;
          end
        end
        if (n == rise_n + 1) chk("bp_gap_valid", 32'(bus.out_valid), 32'd0);
        if (n == rise_n + 2) begin
          chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
          chk("bp_next_addr",  32'(bus.out_addr),  32'd4);
        end
      end
      if (mode == 2 && !s1 && bus.out_valid && bus.out_addr == 3'd2) begin
        start = 1'b1;
        s1 = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (!rnd) chk("done_cycle", 32'(n), 32'(DONE_CYC + (mode == 1 ? 3 : 0)));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (mode == 2) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    dcnt = 0; bcnt = 0;
    repeat (25) begin
      if (done) dcnt++;
      if (busy) bcnt++;
      @(posedge clk); #1;
    end
    chk("extra_done", 32'(dcnt), 32'd0);
    chk("extra_busy", 32'(bcnt), 32'd0);
  endtask

  task automatic run_reset_abort();
    int n, dcnt;
    bit hit;
    push_expected(regs);
    bus.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 0;
    for (n = 0; n < 100; n++) begin
      if (bus.out_valid && bus.out_addr == 3'd4) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rst_reach_beat4", 32'(hit), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    chk_all_zero("rst_mid");
    dcnt = 0;
    repeat (20) begin
      if (done) dcnt++;
      @(posedge clk); #1;
    end
    chk("rst_no_done", 32'(dcnt), 32'd0);
  endtask

  initial begin
    int wb, wj;
    logic [DW-1:0] wv;
    reset = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) regs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all_zero("reset");

    for (int i = 0; i < NREGS; i++) regs[i] = DW'(i + 1);
    run_scan(0, -1, 0, '0, 1'b0);

    for (int i = 0; i < NREGS; i++) regs[i] = DW'(i + 1);
    run_scan(1, -1, 0, '0, 1'b0);

    for (int i = 0; i < NREGS; i++) regs[i] = DW'(i + 1);
    run_scan(0, 2, 6, 8'hAA, 1'b0);

    for (int i = 0; i < NREGS; i++) regs[i] = DW'(i + 1);
    run_scan(2, -1, 0, '0, 1'b0);

    for (int i = 0; i < NREGS; i++) regs[i] = DW'($urandom);
    run_reset_abort();
    for (int i = 0; i < NREGS; i++) regs[i] = DW'($urandom);
    run_scan(0, -1, 0, '0, 1'b0);

    for (int i = 0; i < NREGS; i++) regs[i] = '1;
    run_scan(0, -1, 0, '0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NREGS; i++) regs[i] = DW'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        wb = int'($urandom_range(0, NREGS - 2));
        wj = int'($urandom_range(wb + 1, NREGS - 1));
      end else begin
        wb = -1;
        wj = 0;
      end
      wv = DW'($urandom);
      run_scan(0, wb, wj, wv, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
